pusch_dr_symb_sched: RTL
========================

Name: pusch_dr_symb_sched

Overview:
Symbol scheduler between the CPRI rx unpack stage and the PUSCH dimension-reduction core.
- Collects per-lane end-of-symbol pulses from the enabled CPRI lanes and checks that every enabled lane has delivered the symbol.
- Then issues one start pulse to the core, plus a beam re-sort request according to dr_mode.
- Holds off the next dispatch until the core reports end of packet; drops and flags symbols whose lanes do not all arrive within a timeout.

Parameters:
LANE, 8, number of CPRI rx lanes
TMO_CYC, 4096, cycles allowed from first to last lane iq_last of one symbol
TMO_W, 13, timer width; must satisfy 2^TMO_W > TMO_CYC

Ports:
i_clk  in  1  single clock (data clock domain)
i_rst_n  in  1  asynchronous active-low reset
i_lane_mask  in  LANE  enabled lanes; sampled in IDLE only
i_dr_mode  in  2  re-sort policy: 0 once after reset, 1 slot0/symb0, 2 every symb0, 3 never
i_iq_last  in  LANE  per-lane one-cycle pulse at end of 132-PRB symbol
i_slot_idx  in  7  slot index, valid with any i_iq_last bit
i_symb_idx  in  4  symbol index, valid with any i_iq_last bit
i_core_eop  in  1  core dr_eop, one-cycle pulse
i_clr_stat  in  1  clears sticky flags and counters
o_core_start  out  1  one-cycle dispatch pulse to core
o_resort_req  out  1  one-cycle re-sort request, coincident with o_core_start only
o_slot_idx  out  7  slot of dispatched symbol, held until next dispatch
o_symb_idx  out  4  symbol of dispatched symbol, held until next dispatch
o_busy  out  1  high from o_core_start until i_core_eop accepted
o_lane_miss  out  LANE  sticky OR of lanes missing at timeout
o_dup_err  out  1  sticky: same lane pulsed twice within one collection
o_tmo_cnt  out  16  saturating timeout event count

Behaviour:
- Reset: all outputs 0, state IDLE, seen-mask 0, timer 0, resort_once flag 0.
- States:
  - IDLE: leave when any i_iq_last & mask bit is set. Latch that bit, slot/symb and the mask, then go to COLLECT. Timer starts at 0.
  - COLLECT: seen |= i_iq_last & mask; timer += 1.
    - seen == mask → DISPATCH.
    - Else if timer == TMO_CYC-1 → TIMEOUT.
  - DISPATCH: one cycle. o_core_start=1, o_slot/o_symb updated, o_busy set, seen cleared → WAIT_EOP.
  - WAIT_EOP: pulses for the next symbol accumulate into seen, with slot/symb latched on the first one.
    - On i_core_eop: o_busy cleared.
    - Then: seen == mask → DISPATCH; seen ≠ 0 → COLLECT with timer restarted; else IDLE.
  - TIMEOUT: one cycle. o_lane_miss |= mask & ~seen; o_tmo_cnt += 1 (saturates at 0xFFFF); seen cleared; no start → IDLE.
- Latency: the last required i_iq_last at cycle N gives o_core_start at cycle N+2 (N+1 to enter DISPATCH, registered output).
- Duplicate: an i_iq_last bit already set in seen during COLLECT/WAIT_EOP sets o_dup_err. The pulse is otherwise ignored.
- Mask = 0: the block stays in IDLE and ignores all i_iq_last.
- A single-lane mask goes IDLE→COLLECT→DISPATCH.
- i_core_eop in IDLE/COLLECT is ignored.
- Re-sort is asserted with o_core_start when:
  - mode 0: the first dispatch after reset (resort_once set; cleared only by reset).
  - mode 1: slot==0 && symb==0.
  - mode 2: symb==0.
  - mode 3: never.
- i_clr_stat clears o_lane_miss, o_dup_err and o_tmo_cnt in the same cycle. If it coincides with an update, clear wins.
- Async reset mid-symbol aborts the collection with no start issued.

Optional Feature:
PUSCH_DR_SCHED_STAT_EN
- Defined: o_tmo_cnt is live, and an internal 32-bit dispatched-symbol counter increments on each o_core_start, visible to simulation.
- Undefined: o_tmo_cnt is tied to 0 and the counters are removed. o_lane_miss and o_dup_err are always present.

Decomposition:
- pusch_dr_pkg holds:
  - sched_state_e {IDLE, COLLECT, DISPATCH, WAIT_EOP, TIMEOUT}
  - DR_MODE_ONCE/SLOT0/SYMB0/NONE 2-bit constants
  - SYMB_PER_SLOT=14
- Sub-module pusch_dr_lane_collect holds the seen-mask accumulator, duplicate detect and timer, and returns all_seen, timeout and dup flags. The FSM and re-sort logic stay in the top module.

Test Plan:
- mask=0xFF, lanes 0..7 pulse on cycles 10..17, slot=3, symb=5 → o_core_start at 19, o_slot=3, o_symb=5, o_busy high until i_core_eop, no resort (mode 2).
- mode 0: two full symbols → o_resort_req only with the first start. Mode 1, slot=0, symb=0 → resort; slot=1, symb=0 → none.
- mask=0xFF, lane 6 never pulses → no start; at TMO_CYC cycles after the first pulse o_lane_miss=0x40, o_tmo_cnt=1; i_clr_stat → both 0.
- Next symbol's 8 pulses arrive while o_busy → the start is issued 1 cycle after DISPATCH is entered following i_core_eop, and the latched slot/symb are from the new symbol.
- Lane 2 pulses twice in COLLECT → o_dup_err=1 and normal dispatch. i_rst_n low mid-COLLECT → all outputs 0, no start.
- mask=0x01 single lane, mode 3 → start 2 cycles after the pulse, o_resort_req never asserted.

Source files
------------

// File: rtl/pusch_dr_pkg.sv
// rtl/pusch_dr_pkg.sv - shared types, constants and re-sort policy for the PUSCH DR symbol scheduler
package pusch_dr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DISPATCH,
        WAIT_EOP,
        TIMEOUT
    } sched_state_e;

    localparam logic [1:0] DR_MODE_ONCE  = 2'd0;
    localparam logic [1:0] DR_MODE_SLOT0 = 2'd1;
    localparam logic [1:0] DR_MODE_SYMB0 = 2'd2;
    localparam logic [1:0] DR_MODE_NONE  = 2'd3;

    localparam int SYMB_PER_SLOT = 14;

    // Decide whether a dispatch of (slot, symb) carries a beam re-sort request.
    function automatic logic resort_hit(
        input logic [1:0] mode,
        input logic [6:0] slot,
        input logic [3:0] symb,
        input logic       once_done
    );
        logic hit;
        case (mode)
            DR_MODE_ONCE:  hit = !once_done;
            DR_MODE_SLOT0: hit = (slot == 7'd0) && (symb == 4'd0);
            DR_MODE_SYMB0: hit = (symb == 4'd0);
            default:       hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pusch_dr_lane_collect.sv
// rtl/pusch_dr_lane_collect.sv - per-symbol lane seen-mask, duplicate detect and collection timer
module pusch_dr_lane_collect #(
    parameter int LANE    = 8,
    parameter int TMO_CYC = 4096,
    parameter int TMO_W   = 13
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [LANE-1:0] i_lane_mask,
    input  logic [LANE-1:0] i_iq_last,
    input  logic            i_start,
    input  logic            i_reload,
    input  logic            i_acc,
    input  logic            i_flush,
    input  logic            i_tick,
    output logic [LANE-1:0] o_mask,
    output logic [LANE-1:0] o_seen,
    output logic            o_all_seen,
    output logic            o_any_seen,
    output logic            o_any_hit,
    output logic            o_timeout,
    output logic            o_dup
);

    logic [LANE-1:0]  mask_q, mask_d;
    logic [LANE-1:0]  seen_q, seen_d;
    logic [TMO_W-1:0] timer_q, timer_d;
    logic [LANE-1:0]  hits;

    // Start loads a fresh mask, reload restarts the next symbol, acc ORs in new lanes.
    always_comb begin
        hits   = i_iq_last & mask_q;
        mask_d = mask_q;
        seen_d = seen_q;
        if (i_start) begin
            mask_d = i_lane_mask;
            seen_d = i_iq_last & i_lane_mask;
        end else if (i_reload) begin
            seen_d = hits;
        end else if (i_acc) begin
            seen_d = seen_q | hits;
        end else if (i_flush) begin
            seen_d = '0;
        end
        timer_d = i_tick ? timer_q + 1'b1 : '0;
    end

    // Collection state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mask_q  <= '0;
            seen_q  <= '0;
            timer_q <= '0;
        end else begin
            mask_q  <= mask_d;
            seen_q  <= seen_d;
            timer_q <= timer_d;
        end
    end

    assign o_mask     = mask_q;
    assign o_seen     = seen_q;
    assign o_all_seen = (seen_q == mask_q) && (|mask_q);
    assign o_any_seen = |seen_q;
    assign o_any_hit  = |hits;
    assign o_timeout  = (timer_q == TMO_W'(TMO_CYC - 1));
    assign o_dup      = i_acc && (|(hits & seen_q));

endmodule

// File: rtl/pusch_dr_symb_sched.sv
// rtl/pusch_dr_symb_sched.sv - lane-complete symbol dispatch to the DR core (stats: PUSCH_DR_SCHED_STAT_EN)
module pusch_dr_symb_sched
    import pusch_dr_pkg::*;
#(
    parameter int LANE    = 8,
    parameter int TMO_CYC = 4096,
    parameter int TMO_W   = 13
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [LANE-1:0] i_lane_mask,
    input  logic [1:0]      i_dr_mode,
    input  logic [LANE-1:0] i_iq_last,
    input  logic [6:0]      i_slot_idx,
    input  logic [3:0]      i_symb_idx,
    input  logic            i_core_eop,
    input  logic            i_clr_stat,
    output logic            o_core_start,
    output logic            o_resort_req,
    output logic [6:0]      o_slot_idx,
    output logic [3:0]      o_symb_idx,
    output logic            o_busy,
    output logic [LANE-1:0] o_lane_miss,
    output logic            o_dup_err,
    output logic [15:0]     o_tmo_cnt
);

    sched_state_e    state_q, state_d;
    logic            start_op, reload_op, acc_op, flush_op, tick_op;
    logic            idle_hit, all_seen, any_seen, any_hit, timeout, dup;
    logic [LANE-1:0] mask, seen;
    logic            pend_latch, dispatch;

    logic [6:0]      pend_slot_q, pend_slot_d, slot_q, slot_d;
    logic [3:0]      pend_symb_q, pend_symb_d, symb_q, symb_d;
    logic            core_start_q, core_start_d, resort_q, resort_d;
    logic            resort_once_q, resort_once_d, busy_q, busy_d;
    logic [LANE-1:0] lane_miss_q, lane_miss_d;
    logic            dup_err_q, dup_err_d;

    assign idle_hit = |(i_iq_last & i_lane_mask);

    pusch_dr_lane_collect #(
        .LANE    (LANE),
        .TMO_CYC (TMO_CYC),
        .TMO_W   (TMO_W)
    ) u_collect (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_lane_mask (i_lane_mask),
        .i_iq_last   (i_iq_last),
        .i_start     (start_op),
        .i_reload    (reload_op),
        .i_acc       (acc_op),
        .i_flush     (flush_op),
        .i_tick      (tick_op),
        .o_mask      (mask),
        .o_seen      (seen),
        .o_all_seen  (all_seen),
        .o_any_seen  (any_seen),
        .o_any_hit   (any_hit),
        .o_timeout   (timeout),
        .o_dup       (dup)
    );

    // Next-state and collector operation select.
    always_comb begin
        state_d   = state_q;
        start_op  = 1'b0;
        reload_op = 1'b0;
        acc_op    = 1'b0;
        flush_op  = 1'b0;
        tick_op   = 1'b0;
        case (state_q)
            IDLE: begin
                if (idle_hit) begin
                    start_op = 1'b1;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                acc_op  = 1'b1;
                tick_op = 1'b1;
                if (all_seen) begin
                    state_d = DISPATCH;
                end else if (timeout) begin
                    state_d = TIMEOUT;
                end
            end
            DISPATCH: begin
                reload_op = 1'b1;
                state_d   = WAIT_EOP;
            end
            WAIT_EOP: begin
                acc_op = 1'b1;
                if (i_core_eop) begin
                    if (all_seen) begin
                        state_d = DISPATCH;
                    end else if (any_seen || any_hit) begin
                        state_d = COLLECT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            TIMEOUT: begin
                flush_op = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Symbol tag latch, registered dispatch outputs and sticky status.
    always_comb begin
        pend_latch = ((state_q == IDLE) && idle_hit) ||
                     ((state_q == DISPATCH) && any_hit) ||
                     ((state_q == WAIT_EOP) && !any_seen && any_hit);
        pend_slot_d = pend_latch ? i_slot_idx : pend_slot_q;
        pend_symb_d = pend_latch ? i_symb_idx : pend_symb_q;

        dispatch      = (state_d == DISPATCH);
        core_start_d  = dispatch;
        resort_d      = dispatch && resort_hit(i_dr_mode, pend_slot_q, pend_symb_q, resort_once_q);
        resort_once_d = resort_once_q || (resort_d && (i_dr_mode == DR_MODE_ONCE));
        slot_d        = dispatch ? pend_slot_q : slot_q;
        symb_d        = dispatch ? pend_symb_q : symb_q;
        busy_d        = (state_d == DISPATCH) || (state_d == WAIT_EOP);

        lane_miss_d = lane_miss_q;
        if (state_q == TIMEOUT) begin
            lane_miss_d = lane_miss_q | (mask & ~seen);
        end
        dup_err_d = dup_err_q || dup;
        if (i_clr_stat) begin
            lane_miss_d = '0;
            dup_err_d   = 1'b0;
        end
    end

    // Scheduler state and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            pend_slot_q   <= '0;
            pend_symb_q   <= '0;
            slot_q        <= '0;
            symb_q        <= '0;
            core_start_q  <= 1'b0;
            resort_q      <= 1'b0;
            resort_once_q <= 1'b0;
            busy_q        <= 1'b0;
            lane_miss_q   <= '0;
            dup_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_slot_q   <= pend_slot_d;
            pend_symb_q   <= pend_symb_d;
            slot_q        <= slot_d;
            symb_q        <= symb_d;
            core_start_q  <= core_start_d;
            resort_q      <= resort_d;
            resort_once_q <= resort_once_d;
            busy_q        <= busy_d;
            lane_miss_q   <= lane_miss_d;
            dup_err_q     <= dup_err_d;
        end
    end

`ifdef PUSCH_DR_SCHED_STAT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [31:0] disp_cnt_q, disp_cnt_d;

    // Saturating timeout count and free-running dispatch count.
    always_comb begin
        tmo_cnt_d  = tmo_cnt_q;
        disp_cnt_d = disp_cnt_q;
        if ((state_q == TIMEOUT) && (tmo_cnt_q != 16'hFFFF)) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
        if (core_start_d) begin
            disp_cnt_d = disp_cnt_q + 32'd1;
        end
        if (i_clr_stat) begin
            tmo_cnt_d  = '0;
            disp_cnt_d = '0;
        end
    end

    // Statistics registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt_q  <= '0;
            disp_cnt_q <= '0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            disp_cnt_q <= disp_cnt_d;
        end
    end

    assign o_tmo_cnt = tmo_cnt_q;
`else
    assign o_tmo_cnt = 16'd0;
`endif

    assign o_core_start = core_start_q;
    assign o_resort_req = resort_q;
    assign o_slot_idx   = slot_q;
    assign o_symb_idx   = symb_q;
    assign o_busy       = busy_q;
    assign o_lane_miss  = lane_miss_q;
    assign o_dup_err    = dup_err_q;

endmodule
